// File: rtl/edit_pkg.sv
// rtl/edit_pkg.sv - shared grid defaults, blank character, FSM and step-direction encodings
package edit_pkg;
  localparam int COLS_DEF = 20;
  localparam int ROWS_DEF = 15;
  localparam logic [6:0] BLANK_CHAR = 7'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT,
    ST_WAIT_RECOG,
    ST_WRITE,
    ST_ADVANCE
  } state_t;

  typedef enum logic [1:0] {
    DIR_LEFT,
    DIR_RIGHT,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // Linear character-buffer address of a grid cell, row-major.
  function automatic logic [8:0] lin_addr(input logic [4:0] x, input logic [3:0] y, input int cols);
    int a;
    a = int'(y) * cols + int'(x);
    return 9'(a);
  endfunction
endpackage

// File: rtl/edit_cursor_ctrl_if.sv
// rtl/edit_cursor_ctrl_if.sv - command, recognizer, character-write and display signals of the cursor controller
interface edit_cursor_ctrl_if;
  logic       mv_left;
  logic       mv_right;
  logic       mv_up;
  logic       mv_down;
  logic       start_edit;
  logic       commit;
  logic       cancel;
  logic       backspace;
  logic       recog_valid;
  logic [6:0] recog_char;
  logic       char_wr_en;
  logic [8:0] char_wr_addr;
  logic [6:0] char_wr_data;
  logic       char_wr_ready;
  logic [4:0] writing_block_x_pos;
  logic [3:0] writing_block_y_pos;
  logic       editing;
  logic       canvas_clear;
  logic       busy;

  modport master (
    output mv_left, mv_right, mv_up, mv_down,
    output start_edit, commit, cancel, backspace,
    output recog_valid, recog_char, char_wr_ready,
    input  char_wr_en, char_wr_addr, char_wr_data,
    input  writing_block_x_pos, writing_block_y_pos, editing, canvas_clear, busy
  );

  modport slave (
    input  mv_left, mv_right, mv_up, mv_down,
    input  start_edit, commit, cancel, backspace,
    input  recog_valid, recog_char, char_wr_ready,
    output char_wr_en, char_wr_addr, char_wr_data,
    output writing_block_x_pos, writing_block_y_pos, editing, canvas_clear, busy
  );
endinterface

// File: rtl/grid_pos_step.sv
// rtl/grid_pos_step.sv - one-cell cursor step with row/column wrap around the grid
module grid_pos_step
  import edit_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic [4:0] i_x,
  input  logic [3:0] i_y,
  input  dir_t       i_dir,
  output logic [4:0] o_x,
  output logic [3:0] o_y
);
  localparam logic [4:0] X_MAX = 5'(COLS - 1);
  localparam logic [3:0] Y_MAX = 4'(ROWS - 1);

  always_comb begin
    o_x = i_x;
    o_y = i_y;
    case (i_dir)
      DIR_LEFT: begin
        if (i_x == '0) begin
          o_x = X_MAX;
          o_y = (i_y == '0) ? Y_MAX : i_y - 4'd1;
        end else begin
          o_x = i_x - 5'd1;
        end
      end
      DIR_RIGHT: begin
        if (i_x == X_MAX) begin
          o_x = '0;
          o_y = (i_y == Y_MAX) ? '0 : i_y + 4'd1;
        end else begin
          o_x = i_x + 5'd1;
        end
      end
      DIR_UP:   o_y = (i_y == '0) ? Y_MAX : i_y - 4'd1;
      DIR_DOWN: o_y = (i_y == Y_MAX) ? '0 : i_y + 4'd1;
      default: ;
    endcase
  end
endmodule

// File: rtl/edit_cursor_ctrl.sv
// rtl/edit_cursor_ctrl.sv - cursor movement and handwritten-character edit/write sequencer
module edit_cursor_ctrl
  import edit_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int TIMEOUT = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  edit_cursor_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          r_state;
  logic [4:0]      r_x;
  logic [3:0]      r_y;
  logic [TW-1:0]   r_tmo;
  logic            r_suppress;
  logic            r_wr_en;
  logic [8:0]      r_wr_addr;
  logic [6:0]      r_wr_data;
  logic            r_editing;
  logic            r_busy;
  logic            r_canvas_clear;
  dir_t            w_dir;
  logic [4:0]      w_nx;
  logic [3:0]      w_ny;
  logic            w_any_move;

  assign w_any_move = bus.mv_left | bus.mv_right | bus.mv_up | bus.mv_down;

  // Backspace shares the left step; ADVANCE always steps right.
  always_comb begin
    w_dir = DIR_RIGHT;
    if (r_state == ST_IDLE) begin
      if (bus.backspace || bus.mv_left) w_dir = DIR_LEFT;
      else if (bus.mv_right)            w_dir = DIR_RIGHT;
      else if (bus.mv_up)               w_dir = DIR_UP;
      else if (bus.mv_down)             w_dir = DIR_DOWN;
    end
  end

  grid_pos_step #(.COLS(COLS), .ROWS(ROWS)) u_step (
    .i_x  (r_x),
    .i_y  (r_y),
    .i_dir(w_dir),
    .o_x  (w_nx),
    .o_y  (w_ny)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_x            <= '0;
      r_y            <= '0;
      r_tmo          <= '0;
      r_suppress     <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_editing      <= 1'b0;
      r_busy         <= 1'b0;
      r_canvas_clear <= 1'b0;
    end else begin
      r_canvas_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_edit) begin
            r_state        <= ST_EDIT;
            r_editing      <= 1'b1;
            r_canvas_clear <= 1'b1;
          end else if (bus.backspace) begin
            r_x        <= w_nx;
            r_y        <= w_ny;
            r_wr_addr  <= lin_addr(w_nx, w_ny, COLS);
            r_wr_data  <= BLANK_CHAR;
            r_wr_en    <= 1'b1;
            r_suppress <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_WRITE;
          end else if (w_any_move) begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
        end
        ST_EDIT: begin
          if (bus.cancel) begin
            r_state        <= ST_IDLE;
            r_editing      <= 1'b0;
            r_canvas_clear <= 1'b1;
          end else if (bus.commit) begin
            r_state <= ST_WAIT_RECOG;
            r_busy  <= 1'b1;
            r_tmo   <= '0;
          end
        end
        ST_WAIT_RECOG: begin
          if (bus.recog_valid) begin
            r_wr_addr  <= lin_addr(r_x, r_y, COLS);
            r_wr_data  <= bus.recog_char;
            r_wr_en    <= 1'b1;
            r_suppress <= 1'b0;
            r_editing  <= 1'b0;
            r_state    <= ST_WRITE;
          end else if (r_tmo == TMO_LAST) begin
            r_state        <= ST_IDLE;
            r_editing      <= 1'b0;
            r_busy         <= 1'b0;
            r_canvas_clear <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus.char_wr_ready) begin
            r_wr_en        <= 1'b0;
            r_canvas_clear <= 1'b1;
            r_state        <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (!r_suppress) begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.char_wr_en          = r_wr_en;
  assign bus.char_wr_addr        = r_wr_addr;
  assign bus.char_wr_data        = r_wr_data;
  assign bus.writing_block_x_pos = r_x;
  assign bus.writing_block_y_pos = r_y;
  assign bus.editing             = r_editing;
  assign bus.busy                = r_busy;
  assign bus.canvas_clear        = r_canvas_clear;
endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// tb/tb_edit_cursor_ctrl.sv - directed self-checking bench for edit_cursor_ctrl
module tb_edit_cursor_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   cc_count = 0;

  always #5 clk = ~clk;

  edit_cursor_ctrl_if bus ();

  edit_cursor_ctrl #(.COLS(20), .ROWS(15), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (bus.char_wr_en && bus.char_wr_ready) wr_count++;
    if (bus.canvas_clear) cc_count++;
  end

  localparam logic [7:0] M_LEFT = 8'h01, M_RIGHT = 8'h02, M_UP = 8'h04, M_DOWN = 8'h08;
  localparam logic [7:0] M_START = 8'h10, M_COMMIT = 8'h20, M_CANCEL = 8'h40, M_BKSP = 8'h80;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] m);
    {bus.backspace, bus.cancel, bus.commit, bus.start_edit,
     bus.mv_down, bus.mv_up, bus.mv_right, bus.mv_left} = m;
    tick();
    {bus.backspace, bus.cancel, bus.commit, bus.start_edit,
     bus.mv_down, bus.mv_up, bus.mv_right, bus.mv_left} = '0;
  endtask

  task automatic recog_pulse(input logic [6:0] ch);
    bus.recog_valid = 1'b1;
    bus.recog_char  = ch;
    tick();
    bus.recog_valid = 1'b0;
    bus.recog_char  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== 9'd0) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    checks++;
    if ({bus.editing, bus.busy, bus.char_wr_en, bus.char_wr_addr, bus.char_wr_data, bus.canvas_clear} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outs: ed=%b busy=%b wr=%b addr=%0d data=%h cc=%b want all 0",
               bus.editing, bus.busy, bus.char_wr_en, bus.char_wr_addr, bus.char_wr_data, bus.canvas_clear);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_moves();
    pulse(M_LEFT);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd14}) begin
      errors++;
      $display("FAIL left_wrap: got (%0d,%0d) want (19,14)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    pulse(M_RIGHT);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd0, 4'd0}) begin
      errors++;
      $display("FAIL right_wrap: got (%0d,%0d) want (0,0)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    pulse(M_LEFT | M_RIGHT | M_DOWN);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd14}) begin
      errors++;
      $display("FAIL move_priority: got (%0d,%0d) want (19,14)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    pulse(M_DOWN);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd0}) begin
      errors++;
      $display("FAIL down_wrap: got (%0d,%0d) want (19,0)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    pulse(M_UP);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd14}) begin
      errors++;
      $display("FAIL up_wrap: got (%0d,%0d) want (19,14)", bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
    recog_pulse(7'h55);
    checks++;
    if (bus.busy !== 1'b0 || bus.char_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_recog_dropped: busy=%b wr=%b want 0 0", bus.busy, bus.char_wr_en);
    end
  endtask

  task automatic test_edit_write();
    int w0, c0;
    pulse(M_DOWN);
    pulse(M_DOWN);
    pulse(M_DOWN);
    pulse(M_DOWN);
    pulse(M_START);
    checks++;
    if (bus.editing !== 1'b1 || bus.canvas_clear !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_edit: ed=%b cc=%b busy=%b want 1 1 0", bus.editing, bus.canvas_clear, bus.busy);
    end
    pulse(M_COMMIT);
    checks++;
    if (bus.editing !== 1'b1 || bus.busy !== 1'b1 || bus.canvas_clear !== 1'b0) begin
      errors++;
      $display("FAIL wait_recog: ed=%b busy=%b cc=%b want 1 1 0", bus.editing, bus.busy, bus.canvas_clear);
    end
    w0 = wr_count;
    c0 = cc_count;
    bus.char_wr_ready = 1'b1;
    recog_pulse(7'h41);
    checks++;
    if (bus.char_wr_en !== 1'b1 || bus.char_wr_addr !== 9'd79 || bus.char_wr_data !== 7'h41) begin
      errors++;
      $display("FAIL write_79: en=%b addr=%0d data=%h want 1 79 41", bus.char_wr_en, bus.char_wr_addr, bus.char_wr_data);
    end
    tick();
    bus.char_wr_ready = 1'b0;
    checks++;
    if (bus.char_wr_en !== 1'b0 || bus.canvas_clear !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL advance: en=%b cc=%b busy=%b want 0 1 1", bus.char_wr_en, bus.canvas_clear, bus.busy);
    end
    tick();
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd0, 4'd4} || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL advance_pos: got (%0d,%0d) busy=%b want (0,4) 0",
               bus.writing_block_x_pos, bus.writing_block_y_pos, bus.busy);
    end
    checks++;
    if (wr_count - w0 !== 1 || cc_count - c0 !== 1) begin
      errors++;
      $display("FAIL write_counts: writes=%0d clears=%0d want 1 1", wr_count - w0, cc_count - c0);
    end
  endtask

  task automatic test_ready_stall();
    int w0;
    pulse(M_START);
    pulse(M_COMMIT);
    w0 = wr_count;
    bus.char_wr_ready = 1'b0;
    recog_pulse(7'h42);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.char_wr_en !== 1'b1 || bus.char_wr_addr !== 9'd80 || bus.char_wr_data !== 7'h42) begin
        errors++;
        $display("FAIL stall_hold[%0d]: en=%b addr=%0d data=%h want 1 80 42",
                 i, bus.char_wr_en, bus.char_wr_addr, bus.char_wr_data);
      end
      tick();
    end
    bus.char_wr_ready = 1'b1;
    tick();
    bus.char_wr_ready = 1'b0;
    checks++;
    if (bus.char_wr_en !== 1'b0 || bus.canvas_clear !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: en=%b cc=%b want 0 1", bus.char_wr_en, bus.canvas_clear);
    end
    tick();
    tick();
    checks++;
    if (wr_count - w0 !== 1 || {bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd1, 4'd4}) begin
      errors++;
      $display("FAIL stall_result: writes=%0d pos=(%0d,%0d) want 1 (1,4)",
               wr_count - w0, bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
  endtask

  task automatic test_timeout();
    int w0, c0, k;
    pulse(M_START);
    pulse(M_COMMIT);
    w0 = wr_count;
    c0 = cc_count;
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (k !== 16) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want 16", k);
    end
    checks++;
    if (bus.editing !== 1'b0 || bus.canvas_clear !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: ed=%b cc=%b want 0 1", bus.editing, bus.canvas_clear);
    end
    tick();
    checks++;
    if (wr_count - w0 !== 0 || cc_count - c0 !== 1 ||
        {bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd1, 4'd4}) begin
      errors++;
      $display("FAIL timeout_counts: writes=%0d clears=%0d pos=(%0d,%0d) want 0 1 (1,4)",
               wr_count - w0, cc_count - c0, bus.writing_block_x_pos, bus.writing_block_y_pos);
    end
  endtask

  task automatic test_backspace();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.char_wr_ready = 1'b1;
    pulse(M_BKSP);
    checks++;
    if (bus.char_wr_en !== 1'b1 || bus.char_wr_addr !== 9'd299 || bus.char_wr_data !== 7'h20) begin
      errors++;
      $display("FAIL bksp_write: en=%b addr=%0d data=%h want 1 299 20", bus.char_wr_en, bus.char_wr_addr, bus.char_wr_data);
    end
    tick();
    bus.char_wr_ready = 1'b0;
    tick();
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd14} || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bksp_pos: got (%0d,%0d) busy=%b want (19,14) 0",
               bus.writing_block_x_pos, bus.writing_block_y_pos, bus.busy);
    end
  endtask

  task automatic test_cancel_commit();
    int w0;
    w0 = wr_count;
    pulse(M_START);
    pulse(M_RIGHT);
    checks++;
    if ({bus.writing_block_x_pos, bus.writing_block_y_pos} !== {5'd19, 4'd14} || bus.editing !== 1'b1) begin
      errors++;
      $display("FAIL edit_move_ignored: pos=(%0d,%0d) ed=%b want (19,14) 1",
               bus.writing_block_x_pos, bus.writing_block_y_pos, bus.editing);
    end
    pulse(M_CANCEL | M_COMMIT);
    checks++;
    if (bus.editing !== 1'b0 || bus.busy !== 1'b0 || bus.canvas_clear !== 1'b1) begin
      errors++;
      $display("FAIL cancel_wins: ed=%b busy=%b cc=%b want 0 0 1", bus.editing, bus.busy, bus.canvas_clear);
    end
    tick();
    tick();
    checks++;
    if (wr_count - w0 !== 0 || bus.busy !== 1'b0 || bus.char_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL cancel_nowrite: writes=%0d busy=%b en=%b want 0 0 0", wr_count - w0, bus.busy, bus.char_wr_en);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    pulse(M_START);
    pulse(M_COMMIT);
    bus.char_wr_ready = 1'b0;
    recog_pulse(7'h43);
    checks++;
    if (bus.char_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_write: en=%b want 1", bus.char_wr_en);
    end
    w0 = wr_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.char_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: en=%b busy=%b want 0 0", bus.char_wr_en, bus.busy);
    end
    bus.char_wr_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.char_wr_ready = 1'b0;
    checks++;
    if (wr_count - w0 !== 0 || bus.char_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d en=%b want 0 0", wr_count - w0, bus.char_wr_en);
    end
  endtask

  initial begin
    {bus.backspace, bus.cancel, bus.commit, bus.start_edit,
     bus.mv_down, bus.mv_up, bus.mv_right, bus.mv_left} = '0;
    bus.recog_valid   = 1'b0;
    bus.recog_char    = '0;
    bus.char_wr_ready = 1'b0;
    test_reset();
    test_moves();
    test_edit_write();
    test_ready_stall();
    test_timeout();
    test_backspace();
    test_cancel_commit();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edit_cursor_ctrl.md
EDIT_CURSOR_CTRL -- requirements
Module: edit_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 20, grid columns of 32x32 cells.
REQ-002 SHALL have parameter ROWS, default 15, grid rows of 32x32 cells.
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000, cycles to wait for a recognizer result.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports mv_left, mv_right, mv_up, mv_down  in  1 each  one-cycle cursor-move pulses.
REQ-007 SHALL have ports start_edit, commit, cancel, backspace  in  1 each  one-cycle command pulses.
REQ-008 SHALL have ports recog_valid  in  1, and recog_char  in  7  for the recognized character, valid only with recog_valid.
REQ-009 SHALL have ports char_wr_en  out  1, char_wr_addr  out  9, char_wr_data  out  7, and char_wr_ready  in  1  for the character-buffer write.
REQ-010 SHALL have ports writing_block_x_pos  out  5, writing_block_y_pos  out  4, and editing  out  1  for the pixel generator.
REQ-011 SHALL have ports canvas_clear  out  1 (one-cycle pulse) and busy  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, EDIT, WAIT_RECOG, WRITE, ADVANCE.
REQ-013 SHALL, in IDLE only, apply at most one move per cycle, with priority left > right > up > down.
REQ-014 SHALL wrap right: col COLS-1 -> col 0, row+1; (COLS-1,ROWS-1) -> (0,0).
REQ-015 SHALL wrap left: col 0 -> col COLS-1, row-1; (0,0) -> (COLS-1,ROWS-1).
REQ-016 SHALL wrap up at row 0 to row ROWS-1 and down at row ROWS-1 to row 0, column unchanged.
REQ-017 SHALL, in IDLE, give start_edit priority over moves and backspace: go to EDIT and pulse canvas_clear in the next cycle.
REQ-018 SHALL, on backspace in IDLE with no start_edit, step the position left with wrap, latch data 7'h20, and go to WRITE with the advance step suppressed.
REQ-019 SHALL, in EDIT, ignore moves; cancel -> IDLE with a canvas_clear pulse; commit -> WAIT_RECOG; cancel wins if both arrive in one cycle.
REQ-020 SHALL, in WAIT_RECOG, on recog_valid latch recog_char and go to WRITE.
REQ-021 SHALL, in WAIT_RECOG, go to IDLE with a canvas_clear pulse and no write after TIMEOUT cycles without recog_valid; recog_valid wins over timeout in the same cycle.
REQ-022 SHALL, in WRITE, hold char_wr_en=1 with addr and data stable until char_wr_ready is sampled high, then go to ADVANCE.
REQ-023 SHALL compute char_wr_addr = y*COLS + x from the registered position, range 0..COLS*ROWS-1.
REQ-024 SHALL, in ADVANCE (exactly one cycle), step the position right with wrap unless suppressed, pulse canvas_clear, and go to IDLE.
REQ-025 SHALL drive editing=1 in EDIT and WAIT_RECOG only, and busy=1 in WAIT_RECOG, WRITE, and ADVANCE only.
REQ-026 SHALL drop any input pulse that arrives outside its accepting state, with no queuing.
REQ-027 SHALL keep canvas_clear high for exactly one cycle per event.

Reset
REQ-028 SHALL, while rst=1, set state IDLE, position (0,0), editing=0, busy=0, char_wr_en=0, char_wr_addr=0, char_wr_data=0, canvas_clear=0, and the timeout counter to 0.
REQ-029 SHALL, on rst mid-WRITE, deassert char_wr_en in the next cycle and perform no further write.

Structure
REQ-030 SHALL place COLS/ROWS defaults, BLANK_CHAR=7'h20, and the FSM state encoding in a shared package, edit_pkg.
REQ-031 SHALL use one combinational sub-module, grid_pos_step, which takes the position and a direction and returns the wrapped position.

Verification
REQ-032 SHALL test: reset, then mv_left -> position (19,14); then mv_right -> (0,0).
REQ-033 SHALL test: at (19,3), start_edit, commit, recog_valid with char 7'h41, char_wr_ready high -> write addr 79, data 7'h41, then position (0,4) and one canvas_clear pulse.
REQ-034 SHALL test: char_wr_ready held low for 5 cycles in WRITE -> char_wr_en high with stable addr/data for all 5 cycles, and exactly one write accepted.
REQ-035 SHALL test: commit then no recog_valid, with TIMEOUT=16 -> return to IDLE 16 cycles later, no char_wr_en, and one canvas_clear pulse.
REQ-036 SHALL test: at (0,0), backspace -> write addr 299, data 7'h20; final position (19,14).
REQ-037 SHALL test: cancel and commit in the same EDIT cycle -> IDLE, no write; and rst during WRITE -> char_wr_en=0 in the next cycle.
